signed_2s_comp_sub_serial: RTL and testbench
============================================

SIGNED_2S_COMP_SUB_SERIAL -- requirements
Module: signed_2s_comp_sub_serial

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand and result width in bits (WIDTH >= 2).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port num1, input, WIDTH bits: signed two's complement minuend.
REQ-005 The block SHALL have port num2, input, WIDTH bits: signed two's complement subtrahend.
REQ-006 The block SHALL have port in_valid, input, 1 bit: num1/num2 valid.
REQ-007 The block SHALL have port in_ready, output, 1 bit: block can accept an operand pair.
REQ-008 The block SHALL have port s_sub, output, WIDTH bits: result num1 - num2.
REQ-009 The block SHALL have port ovf, output, 1 bit: signed overflow flag for s_sub.
REQ-010 The block SHALL have port out_valid, output, 1 bit: s_sub/ovf valid.
REQ-011 The block SHALL have port out_ready, input, 1 bit: consumer accepts the result.

Function
REQ-012 The block SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-013 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-014 In IDLE with in_valid=1, the block SHALL latch num1 and num2 at the rising edge, clear the bit counter to 0, set the carry to 1, and enter RUN.
REQ-015 In RUN, each edge SHALL process exactly one bit, LSB first: sum bit = a[i] XOR ~b[i] XOR c; carry = majority(a[i], ~b[i], c).
REQ-016 The sum bit SHALL be shifted into the result register, and the counter SHALL increment each RUN edge.
REQ-017 After WIDTH RUN edges (counter at WIDTH-1), the block SHALL enter DONE.
REQ-018 out_valid SHALL rise exactly WIDTH cycles after the accepting edge.
REQ-019 ovf SHALL be 1 iff num1[MSB] != num2[MSB] and the raw result MSB != num1[MSB]; it SHALL be computed on entry to DONE.
REQ-020 s_sub and ovf SHALL stay stable while out_valid=1 and out_ready=0.
REQ-021 In DONE with out_ready=1, the block SHALL return to IDLE at the next edge; a new operand pair is not accepted in that same cycle.
REQ-022 Input changes on num1, num2 or in_valid during RUN or DONE SHALL be ignored.
REQ-023 The most-negative subtrahend (num2 = 1 followed by WIDTH-1 zeros) SHALL need no special case; the ~b+1 carry-in handles it.
REQ-024 The raw result SHALL wrap modulo 2^WIDTH.

Reset
REQ-025 On rst_n=0 the block SHALL asynchronously enter IDLE, whether or not an operation is in progress.
REQ-026 On reset: s_sub=0, ovf=0, out_valid=0, in_ready=1, counter=0, carry=0.
REQ-027 An operation in progress at reset SHALL be aborted and SHALL produce no result.
REQ-028 The first acceptance after reset release SHALL be possible at the first rising edge with rst_n=1.

Configuration
REQ-029 Macro SIGNED_SUB_SAT_EN SHALL control output saturation.
REQ-030 With SIGNED_SUB_SAT_EN defined, when ovf=1, s_sub SHALL equal the most-positive value if num1 >= 0 and the most-negative value if num1 < 0; ovf SHALL still report 1.
REQ-031 Without SIGNED_SUB_SAT_EN, s_sub SHALL be the wrapped raw result.

Verification (WIDTH=32)
REQ-032 Scenario: num1=32'd1010, num2=32'd1000 -> s_sub=32'd10, ovf=0, out_valid exactly 32 cycles after acceptance.
REQ-033 Scenario: num1=32'd263, num2=-32'h10027383 -> s_sub=32'h1002748A, ovf=0.
REQ-034 Scenario: num1=32'h7FFFFFFF, num2=32'hFFFFFFFF -> ovf=1; s_sub=32'h80000000 without the macro, 32'h7FFFFFFF with it.
REQ-035 Scenario: num1=0, num2=32'h80000000 -> ovf=1; s_sub=32'h80000000 without the macro, 32'h7FFFFFFF with it. Scenario: num1=32'h80000000, num2=1 -> ovf=1; s_sub=32'h7FFFFFFF without the macro, 32'h80000000 with it.
REQ-036 Scenario: out_ready held 0 for 5 cycles in DONE -> s_sub, ovf and out_valid stable; in_valid pulses ignored; the edge after out_ready=1 -> in_ready=1.
REQ-037 Scenario: rst_n pulsed low at RUN bit 10 -> out_valid stays 0, in_ready=1 immediately; the next operation 5-3 -> s_sub=2.

Source files
------------

// File: rtl/signed_2s_comp_sub_serial.sv
// signed_2s_comp_sub_serial: bit-serial signed num1-num2 with valid/ready handshake; SIGNED_SUB_SAT_EN enables saturation
module signed_2s_comp_sub_serial #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] num1,
  input  logic [WIDTH-1:0] num2,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] s_sub,
  output logic             ovf,
  output logic             out_valid,
  input  logic             out_ready
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nxt;
  logic [WIDTH-1:0] a, b, res;
  logic [CW-1:0] cnt;
  logic carry, sum, cout, last;
  assign sum = a[cnt] ^ ~b[cnt] ^ carry;
  assign cout = (a[cnt] & ~b[cnt]) | (a[cnt] & carry) | (~b[cnt] & carry);
  assign last = cnt == CW'(WIDTH - 1);
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  // next state: accept in IDLE, one bit per RUN edge, hold DONE until consumed
  always_comb begin
    state_nxt = state;
    state_nxt = state == IDLE ? (in_valid ? RUN : IDLE) :
                state == RUN  ? (last ? DONE : RUN) :
                                (out_ready ? IDLE : DONE);
  end
  // datapath: latch operands, then add a + ~b + 1 LSB first shifting sums in from the top
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      a     <= '0;
      b     <= '0;
      res   <= '0;
      cnt   <= '0;
      carry <= 1'b0;
      ovf   <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      a     <= num1;
      b     <= num2;
      cnt   <= '0;
      carry <= 1'b1;
      ovf   <= 1'b0;
    end else if (state == RUN) begin
      res   <= {sum, res[WIDTH-1:1]};
      cnt   <= cnt + CW'(1);
      carry <= cout;
      if (last) ovf <= (a[WIDTH-1] ^ b[WIDTH-1]) & (sum ^ a[WIDTH-1]);
    end
`ifdef SIGNED_SUB_SAT_EN
  assign s_sub = ovf ? {a[WIDTH-1], {(WIDTH-1){~a[WIDTH-1]}}} : res;
`else
  assign s_sub = res;
`endif
endmodule

// File: tb/tb_signed_2s_comp_sub_serial.sv
// tb_signed_2s_comp_sub_serial: directed self-checking bench for signed_2s_comp_sub_serial
module tb_signed_2s_comp_sub_serial;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] num1 = '0, num2 = '0, s_sub;
  logic        in_valid = 1'b0, in_ready, ovf, out_valid, out_ready = 1'b0;
  int          n_chk = 0, n_fail = 0;

  signed_2s_comp_sub_serial #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .num1(num1), .num2(num2), .in_valid(in_valid),
    .in_ready(in_ready), .s_sub(s_sub), .ovf(ovf), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic start_op(input logic [31:0] n1, input logic [31:0] n2);
    int cyc;
    @(negedge clk);
    chk("in_ready_idle", in_ready, 1);
    num1 = n1;
    num2 = n2;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    num1 = $urandom;
    num2 = $urandom;
    cyc = 0;
    while (!out_valid && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("latency", cyc, 32);
  endtask

  task automatic finish_op(input string tag, input logic [31:0] es, input logic eo);
    chk({tag, "_s_sub"}, s_sub, es);
    chk({tag, "_ovf"}, ovf, eo);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({tag, "_back_idle"}, in_ready, 1);
    chk({tag, "_ov_low"}, out_valid, 0);
  endtask

  task automatic op(input string tag, input logic [31:0] n1, input logic [31:0] n2,
                    input logic [31:0] es, input logic eo);
    start_op(n1, n2);
    finish_op(tag, es, eo);
  endtask

  initial begin
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_s_sub", s_sub, 0);
    chk("rst_ovf", ovf, 0);
    @(negedge clk);
    rst_n = 1'b1;

    op("small", 32'd1010, 32'd1000, 32'd10, 1'b0);
    op("neg_sub", 32'd263, -32'sh10027383, 32'h1002748A, 1'b0);
    op("neg_res", -32'sd5, 32'd3, 32'hFFFFFFF8, 1'b0);
    op("wrap_neg", 32'd3, 32'd5, 32'hFFFFFFFE, 1'b0);
    op("zero", 32'd0, 32'd0, 32'd0, 1'b0);
`ifdef SIGNED_SUB_SAT_EN
    op("pos_ovf", 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h7FFFFFFF, 1'b1);
    op("min_sub", 32'h0, 32'h80000000, 32'h7FFFFFFF, 1'b1);
    op("neg_ovf", 32'h80000000, 32'd1, 32'h80000000, 1'b1);
`else
    op("pos_ovf", 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000000, 1'b1);
    op("min_sub", 32'h0, 32'h80000000, 32'h80000000, 1'b1);
    op("neg_ovf", 32'h80000000, 32'd1, 32'h7FFFFFFF, 1'b1);
`endif

    start_op(32'd100, 32'd7);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = i[0];
      num1 = $urandom;
      num2 = $urandom;
      @(posedge clk);
      #1;
      chk("hold_s_sub", s_sub, 32'd93);
      chk("hold_ovf", ovf, 0);
      chk("hold_out_valid", out_valid, 1);
      chk("hold_in_ready", in_ready, 0);
    end
    @(negedge clk);
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("release_in_ready", in_ready, 1);
    chk("release_out_valid", out_valid, 0);
    in_valid = 1'b0;
    out_ready = 1'b0;

    @(negedge clk);
    num1 = 32'd40;
    num2 = 32'd1;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_in_ready", in_ready, 1);
    chk("abort_out_valid", out_valid, 0);
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("abort_hold_ov", out_valid, 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    op("after_rst", 32'd5, 32'd3, 32'd2, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
